// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core slice: widths, opcodes, field positions
// and the decoded-instruction record.
package cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int PC_W    = 16;
    localparam int NREGS   = 32;
    localparam int REG_AW  = 5;
    localparam int INSTR_W = 32;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 6;
    localparam int RA_LSB  = 6;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 16;
    localparam int RB_LSB  = 16;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_AND  = 6'd3,
        OP_OR   = 6'd4,
        OP_XOR  = 6'd5,
        OP_SHL  = 6'd6,
        OP_SHR  = 6'd7,
        OP_ADDI = 6'd8,
        OP_LDI  = 6'd14,
        OP_JMP  = 6'd15,
        OP_BEQZ = 6'd16,
        OP_BNEZ = 6'd17,
        OP_HLT  = 6'd31
    } opcode_e;

    // opcode kept as raw bits so undefined encodings survive decode and fall to NOP
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] imm;
    } decoded_t;

    function automatic decoded_t decode(input logic [INSTR_W-1:0] instr);
        decoded_t d;
        d.opcode = instr[OPC_LSB +: OPC_W];
        d.ra     = instr[RA_LSB  +: REG_AW];
        d.rd     = instr[RD_LSB  +: REG_AW];
        d.rb     = instr[RB_LSB  +: REG_AW];
        d.imm    = instr[IMM_LSB +: DATA_W];
        return d;
    endfunction

endpackage

// File: rtl/cpu_if.sv
// Program-ROM fetch bus: the core drives the address, the ROM answers
// combinationally in the same cycle (no handshake, always valid).
interface cpu_if;
    import cpu_pkg::*;

    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    prom_addr;

    modport master (input instruction, output prom_addr);
    modport slave  (output instruction, input prom_addr);
endinterface

// File: rtl/cpu_regfile.sv
// 32 x 16 register file: two asynchronous read ports, one write port,
// r0 hardwired to zero, whole array cleared by asynchronous reset.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not bypassed
    assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 16-bit CPU: decode, ALU and next-PC are combinational,
// each rising edge commits the register write and the new PC.
module cpu_core
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    cpu_if.master prom
);

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    decoded_t          dec;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    assign dec            = decode(prom.instruction);
    assign prom.prom_addr = pc;

    cpu_regfile u_rf (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (dec.ra),
        .rb_addr (dec.rb),
        .ra_data (a_val),
        .rb_data (b_val),
        .wr_en   (wr_en),
        .wr_addr (dec.rd),
        .wr_data (wr_data)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        pc_next = pc + 1'b1;
        case (dec.opcode)
            OP_ADD:  begin wr_en = 1'b1; wr_data = a_val + b_val;       end
            OP_SUB:  begin wr_en = 1'b1; wr_data = a_val - b_val;       end
            OP_AND:  begin wr_en = 1'b1; wr_data = a_val & b_val;       end
            OP_OR:   begin wr_en = 1'b1; wr_data = a_val | b_val;       end
            OP_XOR:  begin wr_en = 1'b1; wr_data = a_val ^ b_val;       end
            OP_SHL:  begin wr_en = 1'b1; wr_data = a_val << b_val[3:0]; end
            OP_SHR:  begin wr_en = 1'b1; wr_data = a_val >> b_val[3:0]; end
            OP_ADDI: begin wr_en = 1'b1; wr_data = a_val + dec.imm;     end
            OP_LDI:  begin wr_en = 1'b1; wr_data = dec.imm;             end
            OP_JMP:  pc_next = dec.imm;
            OP_BEQZ: if (a_val == '0) pc_next = dec.imm;
            OP_BNEZ: if (a_val != '0) pc_next = dec.imm;
            OP_HLT:  pc_next = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: an instruction-level model predicts PC and
// register contents after every edge; literal checks pin key results.
module tb_cpu_core;

  logic clk;
  logic rst;

  cpu_if prom ();

  cpu_core u_dut (
    .clk  (clk),
    .rst  (rst),
    .prom (prom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  bit chk_en;

  // Architectural model
  int m_pc;
  int m_regs [32];

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  function automatic int m_rd(input int idx);
    return (idx == 0) ? 0 : m_regs[idx];
  endfunction

  task automatic model_step(input logic [31:0] ins);
    int op, rd, a, b, imm, res, npc;
    bit wr;
    op  = int'(ins[5:0]);
    rd  = int'(ins[15:11]);
    a   = m_rd(int'(ins[10:6]));
    b   = m_rd(int'(ins[20:16]));
    imm = int'(ins[31:16]);
    res = 0;
    wr  = 1'b1;
    npc = (m_pc + 1) % 65536;
    case (op)
      1:  res = a + b;
      2:  res = a - b;
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  res = a * (2 ** (b % 16));
      7:  res = a / (2 ** (b % 16));
      8:  res = a + imm;
      14: res = imm;
      15: begin wr = 1'b0; npc = imm; end
      16: begin wr = 1'b0; if (a == 0) npc = imm; end
      17: begin wr = 1'b0; if (a != 0) npc = imm; end
      31: begin wr = 1'b0; npc = m_pc; end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 0) m_regs[rd] = res & 32'hFFFF;
    m_pc = npc;
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int ra, input int imm);
    logic [31:0] w;
    w = {imm[15:0], rd[4:0], ra[4:0], op[5:0]};
    return w;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Driver: called at a negedge, leaves at the following negedge
  task automatic apply(input logic [31:0] ins);
    prom.instruction = ins;
    model_step(ins);
    @(negedge clk);
  endtask

  // Compare process: after every rising edge, PC and full register file vs model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      int bad;
      vectors++;
      if (prom.prom_addr !== m_pc[15:0]) begin
        miscompares++;
        $display("FAIL pc @%0t: got 0x%04h, expected 0x%04h", $time, prom.prom_addr, m_pc[15:0]);
      end
      vectors++;
      bad = -1;
      for (int i = 0; i < 32; i++) begin
        if (bad < 0 && u_dut.u_rf.regs[i] !== m_regs[i][15:0]) bad = i;
      end
      if (bad >= 0) begin
        miscompares++;
        $display("FAIL regs[%0d] @%0t: got 0x%04h, expected 0x%04h", bad, $time,
                 u_dut.u_rf.regs[bad], m_regs[bad][15:0]);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_en      = 1'b0;
    rst         = 1'b1;
    prom.instruction = 32'h0;
    model_reset();

    repeat (2) @(negedge clk);
    check("reset_pc", prom.prom_addr, 16'h0000);
    check("reset_r1", u_dut.u_rf.regs[1], 16'h0000);
    chk_en = 1'b1;
    rst    = 1'b0;

    // Load immediates and register add
    apply(32'h0003080E);
    check("ldi_r1", u_dut.u_rf.regs[1], 16'h0003);
    check("ldi_pc1", prom.prom_addr, 16'h0001);
    apply(32'h0007100E);
    check("ldi_r2", u_dut.u_rf.regs[2], 16'h0007);
    check("ldi_pc2", prom.prom_addr, 16'h0002);
    apply(32'h00031041);
    check("add_r2", u_dut.u_rf.regs[2], 16'h0003);
    check("add_pc3", prom.prom_addr, 16'h0003);

    // ALU wrap and shifts
    apply(enc(14, 1, 0, 16'hFFFF));
    apply(enc(8, 2, 1, 1));
    check("addi_wrap", u_dut.u_rf.regs[2], 16'h0000);
    apply(enc(14, 3, 0, 1));
    apply(enc(2, 4, 0, 3));
    check("sub_wrap", u_dut.u_rf.regs[4], 16'hFFFF);
    apply(enc(14, 6, 0, 15));
    apply(enc(6, 7, 3, 6));
    check("shl_15", u_dut.u_rf.regs[7], 16'h8000);
    apply(enc(14, 8, 0, 20));
    apply(enc(7, 9, 7, 8));
    check("shr_20", u_dut.u_rf.regs[9], 16'h0800);
    apply(enc(4, 11, 7, 9));
    check("or", u_dut.u_rf.regs[11], 16'h8800);
    apply(enc(3, 12, 11, 7));
    check("and", u_dut.u_rf.regs[12], 16'h8000);
    apply(enc(5, 13, 11, 9));
    check("xor", u_dut.u_rf.regs[13], 16'h8000);

    // r0 protection
    apply(enc(14, 5, 0, 16'h0055));
    apply(enc(14, 0, 0, 16'h1234));
    apply(enc(1, 5, 0, 0));
    check("r0_zero", u_dut.u_rf.regs[0], 16'h0000);
    check("r0_add", u_dut.u_rf.regs[5], 16'h0000);

    // Same-instruction read and write: old r1 (0xFFFF) + r3 (1)
    apply(enc(1, 1, 1, 3));
    check("rw_same", u_dut.u_rf.regs[1], 16'h0000);

    // Undefined opcode: no write, PC+1
    apply(enc(6'h3E, 10, 7, 16'h1234));
    check("undef_reg", u_dut.u_rf.regs[10], 16'h0000);
    check("undef_pc", prom.prom_addr, 16'd19);

    // Control flow
    apply(enc(15, 0, 0, 16'h0040));
    check("jmp", prom.prom_addr, 16'h0040);
    apply(enc(16, 0, 0, 16'h0100));
    check("beqz_taken", prom.prom_addr, 16'h0100);
    apply(enc(17, 0, 0, 16'h0200));
    check("bnez_not", prom.prom_addr, 16'h0101);
    apply(enc(17, 0, 9, 16'h0200));
    check("bnez_taken", prom.prom_addr, 16'h0200);
    apply(enc(16, 0, 9, 16'h0300));
    check("beqz_not", prom.prom_addr, 16'h0201);
    repeat (3) apply(enc(31, 14, 9, 16'h0300));
    check("hlt_hold", prom.prom_addr, 16'h0201);
    apply(32'h0);
    check("hlt_resume", prom.prom_addr, 16'h0202);

    // PC wrap
    apply(enc(15, 0, 0, 16'hFFFF));
    apply(32'h0);
    check("pc_wrap", prom.prom_addr, 16'h0000);

    // Mid-program reset aborts the in-flight LDI
    prom.instruction = enc(14, 3, 0, 16'h7777);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_pc", prom.prom_addr, 16'h0000);
    check("mid_rst_r7", u_dut.u_rf.regs[7], 16'h0000);
    check("mid_rst_r9", u_dut.u_rf.regs[9], 16'h0000);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_r3", u_dut.u_rf.regs[3], 16'h0000);
    check("rst_hold_pc", prom.prom_addr, 16'h0000);
    rst = 1'b0;
    apply(32'h0);
    check("post_rst_pc", prom.prom_addr, 16'h0001);
    check("post_rst_r3", u_dut.u_rf.regs[3], 16'h0000);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
